uart_tx_port: RTL and testbench

- Memory-mapped serial output device for the 20-bit stack CPU.
- Sits on the CPU's data-memory bus beside main RAM and claims the hardware-register window at the top of the address space.
- CPU stores to the data register enqueue bytes into a small FIFO; a transmit state machine serialises them onto an 8N1 UART line.
- CPU loads from the status register to poll for room.

---
 rtl/uart_tx_port.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_port.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Data register enqueues bytes; status register reports FIFO state and flags.
module uart_tx_port #(
    parameter int WORD_SIZE = 20,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH = 8,
    parameter logic [WORD_SIZE-1:0] TX_ADDR = 'hff81,
    parameter logic [WORD_SIZE-1:0] STATUS_ADDR = 'hff82
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] addr_i,
    input  logic [WORD_SIZE-1:0] value_i,
    input  logic                 write_i,
    output logic [WORD_SIZE-1:0] value_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [BIT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tx_q;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [WORD_SIZE-1:0] addr_q;

    logic wr_tx;
    logic wr_st;
    logic full;
    logic pop;
    logic push;
    logic bit_last;
    logic [3:0] cnt_field;
    logic unused_hi;

    assign wr_tx    = write_i && (addr_i == TX_ADDR);
    assign wr_st    = write_i && (addr_i == STATUS_ADDR);
    assign full     = (count == DEPTH_C);
    assign pop      = (state == IDLE) && (count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = wr_tx && (!full || pop);
    assign bit_last = (bit_cnt == LAST_BIT);
    assign busy_o   = (state != IDLE) || (count != '0);
    assign tx_o     = tx_q;
    assign cnt_field = 4'(count);
    assign unused_hi = ^value_i[WORD_SIZE-1:8];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= value_i[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wr_st) begin
                overflow <= 1'b0;
            end else if (wr_tx && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        bit_cnt <= '0;
                        state   <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx_q    <= shift[0];
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx_q    <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_i;
        end
    end

    // Non-status reads return zero so RAM data can be ORed in externally.
    always_comb begin
        value_o = '0;
        if (addr_q == STATUS_ADDR) begin
            value_o[7:0] = {cnt_field, 1'b0, overflow, busy_o, full};
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port: stimulus queues expected bytes,
// an independent line receiver decodes frames and checks them.
module tb_uart_tx_port;

    localparam int CPB = 4;
    localparam int FLEN = 10 * CPB;
    localparam logic [19:0] TX_A = 20'hff81;
    localparam logic [19:0] ST_A = 20'hff82;
    localparam logic [19:0] RAM_A = 20'h00100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] addr_i = '0;
    logic [19:0] value_i = '0;
    logic        write_i = 1'b0;
    logic [19:0] value_o;
    logic        tx_o;
    logic        busy_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int gap_q[$];

    uart_tx_port #(
        .WORD_SIZE(20),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(8),
        .TX_ADDR(TX_A),
        .STATUS_ADDR(ST_A)
    ) dut (
        .clk(clk),
        .reset(reset),
        .addr_i(addr_i),
        .value_i(value_i),
        .write_i(write_i),
        .value_o(value_o),
        .tx_o(tx_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] st(input int cnt, input int ovf,
                                       input int bsy, input int ful);
        return 32'(cnt * 16 + ovf * 4 + bsy * 2 + ful);
    endfunction

    task automatic bus_write(input logic [19:0] a, input logic [19:0] v);
        @(negedge clk);
        addr_i = a;
        value_i = v;
        write_i = 1'b1;
        @(negedge clk);
        write_i = 1'b0;
        addr_i = '0;
    endtask

    task automatic bus_read(input logic [19:0] a, output logic [19:0] v);
        @(negedge clk);
        addr_i = a;
        write_i = 1'b0;
        @(negedge clk);
        v = value_o;
    endtask

    task automatic send(input logic [19:0] v);
        exp_q.push_back(v[7:0]);
        bus_write(TX_A, v);
    endtask

    // One write per cycle; c0 is the cycle index of the first write edge.
    task automatic burst(input int n, input int acc, output int c0);
        logic [19:0] v;
        c0 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v = 20'($urandom);
            if (i == 0) c0 = cyc + 1;
            if (i < acc) exp_q.push_back(v[7:0]);
            addr_i = TX_A;
            value_i = v;
            write_i = 1'b1;
        end
        @(negedge clk);
        write_i = 1'b0;
        addr_i = '0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = !busy_o;
        end
        check("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic rx_frame(input logic [FLEN-1:0] s);
        logic [7:0] b;
        bit shape_ok;
        shape_ok = 1'b1;
        for (int g = 0; g < 10; g++)
            for (int j = 1; j < CPB; j++)
                if (s[g*CPB+j] != s[g*CPB]) shape_ok = 1'b0;
        if (s[0] != 1'b0 || s[9*CPB] != 1'b1) shape_ok = 1'b0;
        for (int i = 0; i < 8; i++) b[i] = s[(i+1)*CPB];
        check("frame_shape", 32'(shape_ok), 32'd1);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_unexpected: got %0h, required no frame", b);
        end else begin
            check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin : monitor
        logic [FLEN-1:0] samp;
        int k;
        bit inframe;
        int idle_run;
        inframe = 1'b0;
        idle_run = 0;
        k = 0;
        samp = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                inframe = 1'b0;
                idle_run = 0;
            end else if (!inframe) begin
                if (!tx_o) begin
                    inframe = 1'b1;
                    samp = '0;
                    k = 1;
                    gap_q.push_back(idle_run);
                end else begin
                    idle_run++;
                end
            end else begin
                samp[k] = tx_o;
                k++;
                if (k == FLEN) begin
                    rx_frame(samp);
                    inframe = 1'b0;
                    idle_run = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [19:0] rv;
        logic [7:0] d;
        int c0;
        int cs;
        int lvl;
        int idx;
        int n;

        addr_i = ST_A;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_value", 32'(value_o), 32'd0);
        reset = 1'b0;
        bus_read(ST_A, rv);
        check("rst_status", 32'(rv), st(0, 0, 0, 0));

        d = 8'h41;
        send(20'h00041);
        check("w41_idle_cycle", 32'(tx_o), 32'd1);
        check("w41_busy", 32'(busy_o), 32'd1);
        for (int k = 2; k <= 41; k++) begin
            @(negedge clk);
            idx = (k - 2) / CPB;
            lvl = (idx == 0) ? 0 : (idx == 9) ? 1 : int'(d[idx-1]);
            check("w41_wave", 32'(tx_o), 32'(lvl));
        end
        check("w41_busy_stop", 32'(busy_o), 32'd1);
        @(negedge clk);
        check("w41_busy_fall", 32'(busy_o), 32'd0);
        check("w41_tx_end", 32'(tx_o), 32'd1);

        wait_idle();
        gap_q.delete();
        burst(10, 9, c0);
        bus_read(ST_A, rv);
        check("ovf_status", 32'(rv), st(8, 1, 1, 1));
        bus_write(RAM_A, 20'($urandom));
        bus_read(ST_A, rv);
        check("ram_write_ignored", 32'(rv), st(8, 1, 1, 1));
        bus_read(RAM_A, rv);
        check("ram_read_zero", 32'(rv), 32'd0);
        bus_write(ST_A, 20'($urandom));
        bus_read(ST_A, rv);
        check("ovf_clear", 32'(rv), st(8, 0, 1, 1));
        wait_idle();
        check("gap_frames", 32'(gap_q.size()), 32'd9);
        for (int i = 1; i < gap_q.size(); i++)
            check("gap_len", 32'(gap_q[i]), 32'd1);

        burst(9, 9, c0);
        cs = 0;
        while (cyc != c0 + 41 && cs < 200) begin
            @(negedge clk);
            cs++;
        end
        rv = 20'($urandom);
        exp_q.push_back(rv[7:0]);
        addr_i = TX_A;
        value_i = rv;
        write_i = 1'b1;
        @(negedge clk);
        write_i = 1'b0;
        addr_i = '0;
        bus_read(ST_A, rv);
        check("pop_push_status", 32'(rv), st(8, 0, 1, 1));
        wait_idle();

        send(20'h000a7);
        cs = -1;
        for (int i = 0; i < 10 && cs < 0; i++) begin
            @(negedge clk);
            if (!tx_o) cs = cyc;
        end
        check("rst_start_seen", 32'(cs >= 0), 32'd1);
        for (int i = 0; i < 40 && cyc != cs + 17; i++) @(negedge clk);
        check("rst_bit3", 32'(tx_o), 32'd0);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("rst_async_tx", 32'(tx_o), 32'd1);
        check("rst_async_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(ST_A, rv);
        check("rst_mid_status", 32'(rv), st(0, 0, 0, 0));
        send(20'h00055);
        wait_idle();

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if ($urandom_range(0, 3) == 0)
                    bus_write(20'($urandom_range(0, 20'hff00)), 20'($urandom));
                send(20'($urandom));
            end
            wait_idle();
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        bus_read(ST_A, rv);
        check("final_status", 32'(rv), st(0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
